i2c_req_arbiter: RTL and testbench
==================================

// Module: i2c_req_arbiter
// PURPOSE
//  - Shares one I2C master transaction port between two requesters.
//    Req0 is the UART memory-map path; req1 is the board-init sequencer.
//  - Runs one transaction at a time and routes the response back to its owner.
//  - Enforces a response timeout, returning an error response if the master hangs.
// PARAMETERS
//  TimeoutCycles   1000000  cycles from request acceptance to forced timeout (>=4)
// PORTS
//  i_clk                  in   1   system clock
//  i_rst                  in   1   asynchronous, active-high reset
//  i_reqN_valid           in   1   N=0,1: request valid
//  o_reqN_ready           out  1   request accepted when valid&ready
//  i_reqN_slave_address   in   7   7-bit I2C slave address
//  i_reqN_reg_address     in   8   register address
//  i_reqN_burst_count     in   2   bytes-1 (0..3 => 1..4 bytes)
//  i_reqN_wdata           in   32  write bytes, byte0=[7:0]
//  i_reqN_rd_wrn          in   1   1=read, 0=write
//  o_rspN_valid           out  1   response valid, held until i_rspN_ready
//  i_rspN_ready           in   1   response consumed
//  o_rspN_rdata           out  32  read bytes, byte0=[7:0]; 0 on error
//  o_rspN_error           out  1   1 = timeout
//  o_i2c_valid            out  1   request to I2C master
//  i_i2c_ready            in   1   master accepted request
//  o_i2c_slave_address    out  7   latched copy of owner's field
//  o_i2c_reg_address      out  8   "
//  o_i2c_burst_count      out  2   "
//  o_i2c_wdata            out  32  "
//  o_i2c_rd_wrn           out  1   "
//  i_i2c_rsp_valid        in   1   master response valid
//  o_i2c_rsp_ready        out  1   arbiter can take a response
//  i_i2c_rsp_rdata        in   32  master read data
//  o_i2c_abort            out  1   1-cycle pulse on timeout; master returns to idle
//  o_stray_pulse          out  1   1-cycle pulse when an unowned response is dropped
// BEHAVIOUR
//  - Reset: state=IDLE; last_grant=1, so req0 wins first; all outputs 0.
//  - IDLE: sel = round-robin among valid requesters.
//    - Both valid: take the one not equal to last_grant.
//    - o_reqsel_ready=1 (comb.); the other requester's ready=0.
//    - On handshake: latch all fields and owner=sel, clear timer, go to ISSUE.
//  - ISSUE: o_i2c_valid=1 with fields stable.
//    - i_i2c_ready -> WAIT_RSP; the next cycle drops o_i2c_valid.
//  - WAIT_RSP: o_i2c_rsp_ready=1.
//    - i_i2c_rsp_valid -> latch rdata, error=0, go to DELIVER.
//  - Timer runs in ISSUE and WAIT_RSP. At count==TimeoutCycles-1:
//    - 1-cycle o_i2c_abort pulse; rdata=0, error=1; o_i2c_valid drops; go to DELIVER.
//    - A response arriving in that same cycle wins: no abort, error=0.
//  - DELIVER: o_rspowner_valid=1 with rdata/error until i_rspowner_ready.
//    - Then last_grant=owner, go to IDLE.
//    - o_i2c_rsp_ready=0 here.
//  - Stray response (i_i2c_rsp_valid in IDLE or ISSUE): accepted with
//    o_i2c_rsp_ready=1 and discarded; o_stray_pulse for 1 cycle.
//  - Request-to-I2C latency: 1 cycle (accept in IDLE, o_i2c_valid the next cycle).
//    Best-case response latency is 1 cycle.
//  - Only one transaction is outstanding; the non-granted requester stalls with ready=0.
//  - Requesters must hold fields stable while valid and not yet ready.
//  - Reset mid-transaction: immediate return to IDLE; an in-flight response is lost.
//  - Timer width: $clog2(TimeoutCycles); it saturates only via the timeout transition.
// CONFIGURATION
//  - I2C_ARB_FIXED_PRIORITY_EN defined: req0 always wins when both are valid;
//    last_grant is ignored.
//  - Undefined (default): round-robin as above.
// TESTING
//  1. Only req0 write (slave 0x5D, reg 0x07, burst 0), master ready+rsp after 3 cycles:
//     -> o_i2c_valid 1 cycle after accept, o_rsp0_valid, error=0.
//  2. req0 and req1 valid in the same cycle after reset:
//     -> req0 granted first, req1 next.
//     Repeat both valid -> order 0,1,0,1; with I2C_ARB_FIXED_PRIORITY_EN -> 0,0,...
//  3. req1 read, burst 3, rsp rdata=0xA1B2C3D4 -> o_rsp1_rdata=0xA1B2C3D4, o_rsp0_valid stays 0.
//  4. TimeoutCycles=16, master never responds:
//     -> o_i2c_abort at accept+16, then o_rsp0_valid with error=1, rdata=0.
//  5. Response valid in the same cycle as timeout -> error=0, no abort.
//     Later stray response in IDLE -> o_stray_pulse=1, no o_rspN_valid.
//  6. i_rsp0_ready held 0 for 10 cycles in DELIVER:
//     -> rsp held stable, req1 not accepted.
//     Assert i_rst in WAIT_RSP -> all outputs 0 next edge.

Source files
------------

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter
// Shares one I2C master transaction port between two requesters (req0: UART
// memory-map path, req1: board-init sequencer). One transaction is in flight
// at a time. The response is routed back to the requester that owns the
// transaction, and a timeout returns an error response if the master hangs.
//
// Build option:
//   I2C_ARB_FIXED_PRIORITY_EN  defined   -> req0 always wins when both are valid
//                              undefined -> round-robin (default)
module i2c_req_arbiter #(
  parameter int unsigned TimeoutCycles = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst,

  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [6:0]  i_req0_slave_address,
  input  logic [7:0]  i_req0_reg_address,
  input  logic [1:0]  i_req0_burst_count,
  input  logic [31:0] i_req0_wdata,
  input  logic        i_req0_rd_wrn,
  output logic        o_rsp0_valid,
  input  logic        i_rsp0_ready,
  output logic [31:0] o_rsp0_rdata,
  output logic        o_rsp0_error,

  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [6:0]  i_req1_slave_address,
  input  logic [7:0]  i_req1_reg_address,
  input  logic [1:0]  i_req1_burst_count,
  input  logic [31:0] i_req1_wdata,
  input  logic        i_req1_rd_wrn,
  output logic        o_rsp1_valid,
  input  logic        i_rsp1_ready,
  output logic [31:0] o_rsp1_rdata,
  output logic        o_rsp1_error,

  output logic        o_i2c_valid,
  input  logic        i_i2c_ready,
  output logic [6:0]  o_i2c_slave_address,
  output logic [7:0]  o_i2c_reg_address,
  output logic [1:0]  o_i2c_burst_count,
  output logic [31:0] o_i2c_wdata,
  output logic        o_i2c_rd_wrn,
  input  logic        i_i2c_rsp_valid,
  output logic        o_i2c_rsp_ready,
  input  logic [31:0] i_i2c_rsp_rdata,
  output logic        o_i2c_abort,
  output logic        o_stray_pulse
);

  localparam int unsigned TimerWidth = $clog2(TimeoutCycles);
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_DELIVER
  } state_t;

  state_t                state;
  logic                  owner;
  logic [TimerWidth-1:0] timer;
`ifndef I2C_ARB_FIXED_PRIORITY_EN
  logic                  last_grant;
`endif

  logic        sel;
  logic        accept;
  logic        timeout_hit;
  logic        rsp_take;
  logic        timeout_now;
  logic        deliver_now;
  logic        stray_take;
  logic [31:0] deliver_rdata;

  // Pick a requester and present the combinational ready in IDLE
  always_comb begin
`ifdef I2C_ARB_FIXED_PRIORITY_EN
    sel = ~i_req0_valid;
`else
    sel = (i_req0_valid && i_req1_valid) ? ~last_grant : ~i_req0_valid;
`endif
    o_req0_ready = (state == ST_IDLE) && i_req0_valid && !sel;
    o_req1_ready = (state == ST_IDLE) && i_req1_valid && sel;
    accept       = o_req0_ready || o_req1_ready;
  end

  // Response capture, timeout detection (response wins a tie) and stray drop
  always_comb begin
    timeout_hit   = (timer == TimerLast);
    rsp_take      = (state == ST_WAIT_RSP) && i_i2c_rsp_valid;
    timeout_now   = ((state == ST_ISSUE) || (state == ST_WAIT_RSP)) && timeout_hit && !rsp_take;
    deliver_now   = rsp_take || timeout_now;
    deliver_rdata = rsp_take ? i_i2c_rsp_rdata : '0;
    stray_take    = ((state == ST_IDLE) || (state == ST_ISSUE)) && i_i2c_rsp_valid && o_i2c_rsp_ready;
  end

  // Transaction FSM with registered I2C-side and response-side outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state               <= ST_IDLE;
      owner               <= 1'b0;
      timer               <= '0;
`ifndef I2C_ARB_FIXED_PRIORITY_EN
      last_grant          <= 1'b1;
`endif
      o_i2c_valid         <= 1'b0;
      o_i2c_slave_address <= '0;
      o_i2c_reg_address   <= '0;
      o_i2c_burst_count   <= '0;
      o_i2c_wdata         <= '0;
      o_i2c_rd_wrn        <= 1'b0;
      o_i2c_rsp_ready     <= 1'b0;
      o_i2c_abort         <= 1'b0;
      o_stray_pulse       <= 1'b0;
      o_rsp0_valid        <= 1'b0;
      o_rsp0_rdata        <= '0;
      o_rsp0_error        <= 1'b0;
      o_rsp1_valid        <= 1'b0;
      o_rsp1_rdata        <= '0;
      o_rsp1_error        <= 1'b0;
    end else begin
      o_i2c_abort   <= timeout_now;
      o_stray_pulse <= stray_take;
      // Response capture and timeout share one exit to DELIVER from ISSUE/WAIT_RSP
      if (deliver_now) begin
        o_i2c_valid     <= 1'b0;
        o_i2c_rsp_ready <= 1'b0;
        state           <= ST_DELIVER;
        if (owner) begin
          o_rsp1_valid <= 1'b1;
          o_rsp1_rdata <= deliver_rdata;
          o_rsp1_error <= timeout_now;
        end else begin
          o_rsp0_valid <= 1'b1;
          o_rsp0_rdata <= deliver_rdata;
          o_rsp0_error <= timeout_now;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            o_i2c_rsp_ready <= 1'b1;
            if (accept) begin
              owner               <= sel;
              timer               <= '0;
              o_i2c_valid         <= 1'b1;
              o_i2c_slave_address <= sel ? i_req1_slave_address : i_req0_slave_address;
              o_i2c_reg_address   <= sel ? i_req1_reg_address   : i_req0_reg_address;
              o_i2c_burst_count   <= sel ? i_req1_burst_count   : i_req0_burst_count;
              o_i2c_wdata         <= sel ? i_req1_wdata         : i_req0_wdata;
              o_i2c_rd_wrn        <= sel ? i_req1_rd_wrn        : i_req0_rd_wrn;
              state               <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            timer <= timer + 1'b1;
            if (i_i2c_ready) begin
              o_i2c_valid <= 1'b0;
              state       <= ST_WAIT_RSP;
            end
          end
          ST_WAIT_RSP: begin
            timer <= timer + 1'b1;
          end
          ST_DELIVER: begin
            if (owner ? i_rsp1_ready : i_rsp0_ready) begin
              o_rsp0_valid    <= 1'b0;
              o_rsp1_valid    <= 1'b0;
              o_i2c_rsp_ready <= 1'b1;
`ifndef I2C_ARB_FIXED_PRIORITY_EN
              last_grant      <= owner;
`endif
              state           <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter
// Table-driven directed transactions, hand-written corner sequences (stray
// response, reset mid-transaction) and randomized transactions checked
// against a transaction-level model of grant order and timeout outcome.
module tb_i2c_req_arbiter;

  localparam int unsigned T = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i_req0_valid, o_req0_ready, i_req0_rd_wrn;
  logic [6:0]  i_req0_slave_address;
  logic [7:0]  i_req0_reg_address;
  logic [1:0]  i_req0_burst_count;
  logic [31:0] i_req0_wdata;
  logic        o_rsp0_valid, i_rsp0_ready, o_rsp0_error;
  logic [31:0] o_rsp0_rdata;
  logic        i_req1_valid, o_req1_ready, i_req1_rd_wrn;
  logic [6:0]  i_req1_slave_address;
  logic [7:0]  i_req1_reg_address;
  logic [1:0]  i_req1_burst_count;
  logic [31:0] i_req1_wdata;
  logic        o_rsp1_valid, i_rsp1_ready, o_rsp1_error;
  logic [31:0] o_rsp1_rdata;
  logic        o_i2c_valid, i_i2c_ready, o_i2c_rd_wrn;
  logic [6:0]  o_i2c_slave_address;
  logic [7:0]  o_i2c_reg_address;
  logic [1:0]  o_i2c_burst_count;
  logic [31:0] o_i2c_wdata;
  logic        i_i2c_rsp_valid, o_i2c_rsp_ready, o_i2c_abort, o_stray_pulse;
  logic [31:0] i_i2c_rsp_rdata;

  i2c_req_arbiter #(.TimeoutCycles(T)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
    .i_req0_slave_address(i_req0_slave_address), .i_req0_reg_address(i_req0_reg_address),
    .i_req0_burst_count(i_req0_burst_count), .i_req0_wdata(i_req0_wdata),
    .i_req0_rd_wrn(i_req0_rd_wrn), .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(i_rsp0_ready),
    .o_rsp0_rdata(o_rsp0_rdata), .o_rsp0_error(o_rsp0_error),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
    .i_req1_slave_address(i_req1_slave_address), .i_req1_reg_address(i_req1_reg_address),
    .i_req1_burst_count(i_req1_burst_count), .i_req1_wdata(i_req1_wdata),
    .i_req1_rd_wrn(i_req1_rd_wrn), .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(i_rsp1_ready),
    .o_rsp1_rdata(o_rsp1_rdata), .o_rsp1_error(o_rsp1_error),
    .o_i2c_valid(o_i2c_valid), .i_i2c_ready(i_i2c_ready),
    .o_i2c_slave_address(o_i2c_slave_address), .o_i2c_reg_address(o_i2c_reg_address),
    .o_i2c_burst_count(o_i2c_burst_count), .o_i2c_wdata(o_i2c_wdata),
    .o_i2c_rd_wrn(o_i2c_rd_wrn), .i_i2c_rsp_valid(i_i2c_rsp_valid),
    .o_i2c_rsp_ready(o_i2c_rsp_ready), .i_i2c_rsp_rdata(i_i2c_rsp_rdata),
    .o_i2c_abort(o_i2c_abort), .o_stray_pulse(o_stray_pulse)
  );

  typedef struct packed {
    logic [6:0]  sa;
    logic [7:0]  ra;
    logic [1:0]  bc;
    logic [31:0] wd;
    logic        rw;
  } req_t;

  typedef struct {
    logic [1:0]  raise;
    req_t        f;
    int          a;
    int          r;
    logic [31:0] rd;
    int          hold;
    int          exp_own;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  req_t fld [2];
  logic [1:0] pend;
  int   last;
  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic req_t mk(input logic [6:0] sa, input logic [7:0] ra, input logic [1:0] bc,
                              input logic [31:0] wd, input logic rw);
    req_t f;
    f.sa = sa; f.ra = ra; f.bc = bc; f.wd = wd; f.rw = rw;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    i_req0_valid = pend[0];
    i_req0_slave_address = fld[0].sa; i_req0_reg_address = fld[0].ra;
    i_req0_burst_count = fld[0].bc; i_req0_wdata = fld[0].wd; i_req0_rd_wrn = fld[0].rw;
    i_req1_valid = pend[1];
    i_req1_slave_address = fld[1].sa; i_req1_reg_address = fld[1].ra;
    i_req1_burst_count = fld[1].bc; i_req1_wdata = fld[1].wd; i_req1_rd_wrn = fld[1].rw;
  endtask

  // New requests only replace fields of requesters that are not already waiting
  task automatic raise_reqs(input logic [1:0] raise, input req_t f);
    if (raise[0] && !pend[0]) begin
      pend[0] = 1'b1;
      fld[0]  = f;
    end
    if (raise[1] && !pend[1]) begin
      pend[1]   = 1'b1;
      fld[1]    = f;
      fld[1].sa = f.sa ^ 7'h11;
      fld[1].wd = ~f.wd;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid, o_rsp0_error,
                           o_rsp1_error, o_i2c_valid, o_i2c_rd_wrn, o_i2c_rsp_ready, o_i2c_abort,
                           o_stray_pulse}, 0);
    check({tag, "_rdata"}, {o_rsp0_rdata, o_rsp1_rdata}, 0);
    check({tag, "_fields"}, {o_i2c_wdata, o_i2c_slave_address, o_i2c_reg_address,
                             o_i2c_burst_count}, 0);
  endtask

  // One full transaction: grant, issue after a master-ready delay a, response r
  // cycles after the I2C handshake (never, if the timeout comes first), then a
  // response-ready stall of hold cycles at the owner.
  task automatic run_txn(input int exp_own, input int a, input int r, input logic [31:0] rd,
                         input int hold, input logic exp_err, input logic [31:0] exp_rd);
    int   e;
    int   waited;
    int   rsp_e;
    logic seen_abort;
    logic [1:0] rdy;
    req_t f;
    drive_reqs();
    #1;
    waited = 0;
    while (!(o_req0_ready || o_req1_ready) && waited < 4) begin
      tick(); #1;
      waited++;
    end
    rdy = {o_req1_ready, o_req0_ready};
    check("grant", rdy, 2'b01 << exp_own);
    f = fld[exp_own];
    tick();
    pend[exp_own] = 1'b0;
    drive_reqs();
    e = 0;
    #1;
    check("i2c_valid_after_accept", o_i2c_valid, 1);
    check("i2c_fields", {o_i2c_slave_address, o_i2c_reg_address, o_i2c_burst_count,
                         o_i2c_wdata, o_i2c_rd_wrn}, f);
    check("other_stalled", exp_own ? o_req0_ready : o_req1_ready, 0);
    repeat (a) begin
      tick(); e++; #1;
      check("i2c_valid_held", o_i2c_valid, 1);
    end
    i_i2c_ready = 1'b1;
    tick(); e++;
    i_i2c_ready = 1'b0;
    #1;
    check("i2c_valid_dropped", o_i2c_valid, 0);
    rsp_e = 2 + a + r;
    seen_abort = 1'b0;
    while (!seen_abort && e < rsp_e - 1 && e < int'(T) + 4) begin
      tick(); e++; #1;
      if (o_i2c_abort) seen_abort = 1'b1;
    end
    if (exp_err) check("abort_at_accept_plus_T", e, T);
    if (!seen_abort && !exp_err) begin
      i_i2c_rsp_valid = 1'b1;
      i_i2c_rsp_rdata = rd;
      #1;
      check("i2c_rsp_ready_wait", o_i2c_rsp_ready, 1);
      tick(); e++;
      i_i2c_rsp_valid = 1'b0;
      i_i2c_rsp_rdata = 32'h0;
      #1;
    end
    check("abort_pulse", o_i2c_abort, exp_err);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        tick(); #1;
        check("deliver_no_accept", o_req0_ready | o_req1_ready, 0);
      end
      if (h == 1) check("abort_one_cycle", o_i2c_abort, 0);
      check("rsp_valid_owner", exp_own ? o_rsp1_valid : o_rsp0_valid, 1);
      check("rsp_valid_other", exp_own ? o_rsp0_valid : o_rsp1_valid, 0);
      check("rsp_rdata", exp_own ? o_rsp1_rdata : o_rsp0_rdata, exp_rd);
      check("rsp_error", exp_own ? o_rsp1_error : o_rsp0_error, exp_err);
      check("i2c_rsp_ready_deliver", o_i2c_rsp_ready, 0);
    end
    if (exp_own == 1) i_rsp1_ready = 1'b1; else i_rsp0_ready = 1'b1;
    tick();
    i_rsp0_ready = 1'b0;
    i_rsp1_ready = 1'b0;
    #1;
    check("rsp_cleared", {o_rsp1_valid, o_rsp0_valid}, 0);
    last = exp_own;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // raise, fields, a, r, master rdata, hold, expected owner/error/rdata
    tbl[0] = '{2'b11, mk(7'h5D, 8'h07, 2'd0, 32'h000000AA, 1'b0), 2, 1,  32'h00000000, 0,  0, 1'b0, 32'h00000000};
    tbl[1] = '{2'b00, mk(7'h00, 8'h00, 2'd0, 32'h0,        1'b0), 0, 0,  32'h11223344, 0,  1, 1'b0, 32'h11223344};
    tbl[2] = '{2'b11, mk(7'h20, 8'h40, 2'd1, 32'h12345678, 1'b1), 1, 2,  32'hCAFEF00D, 0,  0, 1'b0, 32'hCAFEF00D};
    tbl[3] = '{2'b00, mk(7'h00, 8'h00, 2'd0, 32'h0,        1'b0), 0, 3,  32'h00000000, 1,  1, 1'b0, 32'h00000000};
    tbl[4] = '{2'b10, mk(7'h50, 8'h10, 2'd3, 32'h0,        1'b1), 0, 1,  32'hA1B2C3D4, 0,  1, 1'b0, 32'hA1B2C3D4};
    tbl[5] = '{2'b01, mk(7'h5D, 8'h08, 2'd0, 32'h00000055, 1'b0), 0, 15, 32'hDEADBEEF, 0,  0, 1'b1, 32'h00000000};
    tbl[6] = '{2'b10, mk(7'h33, 8'h01, 2'd2, 32'h0,        1'b1), 0, 14, 32'h0F0F0F0F, 0,  1, 1'b0, 32'h0F0F0F0F};
    tbl[7] = '{2'b11, mk(7'h44, 8'h02, 2'd0, 32'h00000001, 1'b0), 1, 0,  32'h00000077, 10, 0, 1'b0, 32'h00000077};
    tbl[8] = '{2'b00, mk(7'h00, 8'h00, 2'd0, 32'h0,        1'b0), 3, 11, 32'h89ABCDEF, 0,  1, 1'b0, 32'h89ABCDEF};
    tbl[9] = '{2'b01, mk(7'h7F, 8'hFF, 2'd3, 32'hFFFFFFFF, 1'b1), 3, 12, 32'h13579BDF, 2,  0, 1'b1, 32'h00000000};

    rst = 1'b1;
    pend = 2'b00;
    fld[0] = '0;
    fld[1] = '0;
    last = 1;
    drive_reqs();
    i_rsp0_ready = 1'b0; i_rsp1_ready = 1'b0;
    i_i2c_ready = 1'b0; i_i2c_rsp_valid = 1'b0; i_i2c_rsp_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      raise_reqs(tbl[i].raise, tbl[i].f);
      run_txn(tbl[i].exp_own, tbl[i].a, tbl[i].r, tbl[i].rd, tbl[i].hold,
              tbl[i].exp_err, tbl[i].exp_rd);
    end

    // Stray response while idle: accepted, flagged, never delivered
    i_i2c_rsp_valid = 1'b1;
    i_i2c_rsp_rdata = 32'h5A5A5A5A;
    #1;
    check("stray_rsp_ready", o_i2c_rsp_ready, 1);
    tick();
    i_i2c_rsp_valid = 1'b0;
    #1;
    check("stray_pulse", o_stray_pulse, 1);
    check("stray_no_rsp", {o_rsp1_valid, o_rsp0_valid}, 0);
    check("stray_no_issue", o_i2c_valid, 0);
    tick(); #1;
    check("stray_pulse_one_cycle", o_stray_pulse, 0);

    // Reset while waiting for the master response
    raise_reqs(2'b01, mk(7'h2A, 8'h3C, 2'd1, 32'hA5A5A5A5, 1'b1));
    drive_reqs();
    #1;
    check("rst_seq_grant", o_req0_ready, 1);
    tick();
    pend = 2'b00;
    drive_reqs();
    i_i2c_ready = 1'b1;
    tick();
    i_i2c_ready = 1'b0;
    #1;
    check("rst_seq_wait_rsp_ready", o_i2c_rsp_ready, 1);
    check("rst_seq_wait_i2c_valid", o_i2c_valid, 0);
    rst = 1'b1;
    tick(); #1;
    check_all_zero("reset_mid_txn");
    rst = 1'b0;
    last = 1;
    tick();
    raise_reqs(2'b11, mk(7'h12, 8'h34, 2'd2, 32'h0BADF00D, 1'b0));
    run_txn(0, 0, 2, 32'h24681357, 0, 1'b0, 32'h24681357);
    run_txn(1, 1, 1, 32'h97531864, 0, 1'b0, 32'h97531864);

    // Randomized transactions against the grant/timeout model
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  raise;
      logic [31:0] rd;
      req_t        f;
      int          a, r, hold, own;
      logic        err;
      raise = 2'($urandom_range(0, 3));
      if ((pend | raise) == 2'b00) raise = 2'b01 << $urandom_range(0, 1);
      f = mk(7'($urandom), 8'($urandom), 2'($urandom), $urandom, 1'($urandom));
      raise_reqs(raise, f);
      own  = (pend == 2'b11) ? 1 - last : (pend[1] ? 1 : 0);
      a    = int'($urandom_range(0, 3));
      r    = int'($urandom_range(0, 18));
      hold = int'($urandom_range(0, 3));
      rd   = $urandom;
      err  = (2 + a + r) > int'(T);
      run_txn(own, a, r, rd, hold, err, err ? 32'h0 : rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
